// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared field positions, mux select codes and widths for the DSP48A1 slice
package dsp48a1_pkg;
  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN = 5;
  localparam int OP_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M = 2'd1;
  localparam logic [1:0] X_P = 2'd2;
  localparam logic [1:0] X_DAB = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P = 2'd2;
  localparam logic [1:0] Z_C = 2'd3;
  function automatic logic [P_W-1:0] sext_m(input logic [M_W-1:0] m);
    return {{(P_W-M_W){m[M_W-1]}}, m};
  endfunction
endpackage

// File: rtl/dsp_post_adder_pipe_stage.sv
// pipe_stage: enable register with async active-high reset, or a plain wire when EN=0
module pipe_stage #(
  parameter int W = 1,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (EN) begin : g_reg
    logic [W-1:0] q_q;
    // reset dominates the enable; otherwise load on ce, else hold
    always_ff @(posedge clk or posedge rst)
      if (rst) q_q <= '0;
      else if (ce) q_q <= d;
    assign q = q_q;
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end
endmodule

// File: rtl/dsp_post_adder.sv
// dsp_post_adder: X/Z muxes, add/subtract with carry-in and pipelined P/carryout of the DSP48A1 slice
module dsp_post_adder
  import dsp48a1_pkg::*;
#(
  parameter int CREG = 1,
  parameter int OPMODEREG = 1,
  parameter int CARRYINREG = 1,
  parameter int PREG = 1,
  parameter int CARRYOUTREG = 1,
  parameter CARRYINSEL = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce_c,
  input  logic           ce_opmode,
  input  logic           ce_carryin,
  input  logic           ce_p,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m_in,
  input  logic [P_W-1:0] c_in,
  input  logic [P_W-1:0] dab_in,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout
);
  if (CARRYINSEL != "OPMODE5" && CARRYINSEL != "CARRYIN") begin : g_bad_sel
    $fatal(1, "dsp_post_adder: CARRYINSEL must be OPMODE5 or CARRYIN");
  end
  logic [P_W-1:0] c_q, p_q, x_mux, z_mux;
  logic [7:0]     opm_q;
  logic [1:0]     x_sel, z_sel;
  logic           cin_d, cin_q, co_q;
  logic [P_W:0]   cin_w, r_d;
  logic           unused_op;
  assign cin_d = (CARRYINSEL == "CARRYIN") ? carryin : opmode[OP_CIN];
  pipe_stage #(.W(P_W), .EN(CREG != 0)) u_c (
    .clk(clk), .rst(rst), .ce(ce_c), .d(c_in), .q(c_q));
  pipe_stage #(.W(8), .EN(OPMODEREG != 0)) u_opm (
    .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(opm_q));
  pipe_stage #(.W(1), .EN(CARRYINREG != 0)) u_cin (
    .clk(clk), .rst(rst), .ce(ce_carryin), .d(cin_d), .q(cin_q));
  pipe_stage #(.W(P_W), .EN(PREG != 0)) u_p (
    .clk(clk), .rst(rst), .ce(ce_p), .d(r_d[P_W-1:0]), .q(p_q));
  pipe_stage #(.W(1), .EN(CARRYOUTREG != 0)) u_co (
    .clk(clk), .rst(rst), .ce(ce_carryin), .d(r_d[P_W]), .q(co_q));
  assign x_sel = opm_q[OP_X_LSB +: 2];
  assign z_sel = opm_q[OP_Z_LSB +: 2];
  assign unused_op = ^{opm_q[6], opm_q[OP_CIN], opm_q[4]};
  // operand selection and 49-bit add/subtract; bit 48 is carry or borrow
  always_comb begin
    x_mux = x_sel == X_M ? sext_m(m_in) : x_sel == X_P ? p_q : x_sel == X_DAB ? dab_in : '0;
    z_mux = z_sel == Z_PCIN ? pcin : z_sel == Z_P ? p_q : z_sel == Z_C ? c_q : '0;
    cin_w = {{P_W{1'b0}}, cin_q};
    r_d = opm_q[OP_SUB] ? {1'b0, z_mux} - ({1'b0, x_mux} + cin_w)
                        : {1'b0, z_mux} + {1'b0, x_mux} + cin_w;
  end
  if (PREG == 0) begin : g_fb_chk
    // feedback through an unregistered P would be a combinational loop
    always @(posedge clk)
      assert (rst || (x_sel != X_P && z_sel != Z_P))
        else $error("dsp_post_adder: P feedback selected with PREG=0");
  end
  assign p = p_q;
  assign pcout = p_q;
  assign carryout = co_q;
endmodule

// File: tb/tb_dsp_post_adder.sv
// tb_dsp_post_adder: vector table plus hand sequences for reset, MAC, latency, ce hold and carry-in select
module tb_dsp_post_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_c = 1'b1, ce_opmode = 1'b1, ce_carryin = 1'b1, ce_p = 1'b1;
  logic [7:0]  opmode = '0;
  logic [35:0] m_in = '0;
  logic [47:0] c_in = '0, dab_in = '0, pcin = '0;
  logic        carryin = 1'b0;
  logic [47:0] p, pcout, p2, pcout2;
  logic        carryout, carryout2;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  op;
    logic [35:0] m;
    logic [47:0] c;
    logic [47:0] dab;
    logic [47:0] pc;
    logic [47:0] p;
    logic        co;
  } vec_t;
  typedef struct {
    logic [47:0] p;
    logic        co;
  } exp_t;
  vec_t tbl[12];
  exp_t sb[$];

  dsp_post_adder dut (
    .clk(clk), .rst(rst), .ce_c(ce_c), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m_in(m_in), .c_in(c_in), .dab_in(dab_in), .pcin(pcin), .carryin(carryin),
    .p(p), .pcout(pcout), .carryout(carryout));

  dsp_post_adder #(.CARRYINSEL("CARRYIN")) dut2 (
    .clk(clk), .rst(rst), .ce_c(ce_c), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode), .m_in(m_in), .c_in(c_in), .dab_in(dab_in), .pcin(pcin), .carryin(carryin),
    .p(p2), .pcout(pcout2), .carryout(carryout2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, p);
    end else begin
      e = sb.pop_front();
      check({name, ".p"}, p, e.p);
      check({name, ".pcout"}, pcout, e.p);
      check({name, ".co"}, {47'd0, carryout}, {47'd0, e.co});
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [35:0] m, input logic [47:0] c,
                       input logic [47:0] dab, input logic [47:0] pc);
    opmode = op;
    m_in = m;
    c_in = c;
    dab_in = dab;
    pcin = pc;
  endtask

  initial begin
    tbl[0]  = '{8'h0D, 36'hF_FFFF_FFFD, 48'd100,   48'd0,             48'd0,      48'd97,             1'b1};
    tbl[1]  = '{8'h8D, 36'd5,           48'd2,     48'd0,             48'd0,      48'hFFFF_FFFF_FFFD, 1'b1};
    tbl[2]  = '{8'h23, 36'd0,           48'd0,     48'hFFFF_FFFF_FFFF, 48'd0,     48'd0,              1'b1};
    tbl[3]  = '{8'h04, 36'd0,           48'd0,     48'd0,             48'h1234,   48'h1234,           1'b0};
    tbl[4]  = '{8'h0D, 36'd7,           48'd10,    48'd0,             48'd0,      48'd17,             1'b0};
    tbl[5]  = '{8'h07, 36'd0,           48'd0,     48'h1000,          48'h0234,   48'h1234,           1'b0};
    tbl[6]  = '{8'h8F, 36'd0,           48'h100,   48'h50,            48'd0,      48'hB0,             1'b0};
    tbl[7]  = '{8'hA5, 36'd4,           48'd0,     48'd0,             48'd10,     48'd5,              1'b0};
    tbl[8]  = '{8'hAC, 36'd0,           48'd0,     48'd0,             48'd0,      48'hFFFF_FFFF_FFFF, 1'b1};
    tbl[9]  = '{8'h01, 36'h8_0000_0000, 48'd0,     48'd0,             48'd0,      48'hFFF8_0000_0000, 1'b0};
    tbl[10] = '{8'h50, 36'd9,           48'd9,     48'd9,             48'd9,      48'd0,              1'b0};
    tbl[11] = '{8'h3D, 36'd1,           48'd1,     48'd0,             48'd0,      48'd3,              1'b0};

    #12;
    check("reset.p", p, 48'd0);
    check("reset.pcout", pcout, 48'd0);
    check("reset.co", {47'd0, carryout}, 48'd0);
    step(1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].m, tbl[i].c, tbl[i].dab, tbl[i].pc);
      sb.push_back('{tbl[i].p, tbl[i].co});
      step(2);
      pop_check($sformatf("vec%0d", i));
    end

    #2 rst = 1'b1;
    #1;
    check("async_rst.p", p, 48'd0);
    check("async_rst.pcout", pcout, 48'd0);
    check("async_rst.co", {47'd0, carryout}, 48'd0);
    step(1);
    check("rst_over_ce.p", p, 48'd0);
    rst = 1'b0;

    drive(8'h09, 36'd0, 48'd0, 48'd0, 48'd0);
    step(1);
    check("mac_prime.p", p, 48'd0);
    m_in = 36'd5;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back('{48'(5 * k), 1'b0});
      step(1);
      pop_check($sformatf("mac%0d", k));
    end

    drive(8'h0D, 36'hF_FFFF_FFFD, 48'd100, 48'd0, 48'd0);
    sb.push_back('{48'd17, 1'b1});
    step(1);
    pop_check("lat_edge1");
    sb.push_back('{48'd97, 1'b1});
    step(1);
    pop_check("lat_edge2");

    drive(8'h04, 36'd0, 48'd0, 48'd0, 48'h1234);
    step(2);
    check("casc.p", p, 48'h1234);
    ce_p = 1'b0;
    pcin = 48'h9999;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("hold.p", p, 48'h1234);
      check("hold.pcout", pcout, 48'h1234);
    end
    ce_p = 1'b1;
    step(1);
    check("resume.p", p, 48'h9999);

    drive(8'h23, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0);
    carryin = 1'b0;
    step(2);
    check("cinsel_op5.p", p, 48'd0);
    check("cinsel_op5.co", {47'd0, carryout}, 48'd1);
    check("cinsel_pin0.p", p2, 48'hFFFF_FFFF_FFFF);
    check("cinsel_pin0.co", {47'd0, carryout2}, 48'd0);
    opmode = 8'h03;
    carryin = 1'b1;
    step(2);
    check("cinsel_op5_0.p", p, 48'hFFFF_FFFF_FFFF);
    check("cinsel_op5_0.co", {47'd0, carryout}, 48'd0);
    check("cinsel_pin1.p", p2, 48'd0);
    check("cinsel_pin1.pcout", pcout2, 48'd0);
    check("cinsel_pin1.co", {47'd0, carryout2}, 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
